// File: rtl/pc_stack_unit.sv
// Program counter with a hardware return-address LIFO for the Dyna-85 fetch path.
// Optional PC-relative branch (pc_rel/rel_off ports) is enabled by defining PC_REL_BRANCH_EN.
module pc_stack_unit #(
    parameter int                ADDR_W      = 16,
    parameter int                STACK_DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_VEC   = '0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               pc_inc,
    input  logic                               pc_load,
    input  logic                               pc_call,
    input  logic                               pc_ret,
`ifdef PC_REL_BRANCH_EN
    input  logic                               pc_rel,
    input  logic signed [7:0]                  rel_off,
`endif
    input  logic [ADDR_W-1:0]                  jmp_add,
    output logic [ADDR_W-1:0]                  pc_out,
    output logic [ADDR_W-1:0]                  stack_top,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_cnt,
    output logic                               stack_full,
    output logic                               stack_empty,
    output logic                               stack_err
);

    localparam int CNT_W = $clog2(STACK_DEPTH + 1);
    localparam int PTR_W = $clog2(STACK_DEPTH);

    logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];
    logic [ADDR_W-1:0] pc_nxt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              err_nxt;
    logic              push;
    logic [PTR_W-1:0]  wr_idx;
    logic [PTR_W-1:0]  top_idx;

`ifdef PC_REL_BRANCH_EN
    // Offset is sign-extended to the PC width; the add wraps modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] rel_target(input logic [ADDR_W-1:0] pc,
                                                     input logic signed [7:0] off);
        logic signed [ADDR_W-1:0] ext;
        ext = ADDR_W'(off);
        return pc + ADDR_W'(ext);
    endfunction
`endif

    assign stack_full  = (stack_cnt == CNT_W'(STACK_DEPTH));
    assign stack_empty = (stack_cnt == '0);
    assign wr_idx      = PTR_W'(stack_cnt);
    assign top_idx     = PTR_W'(stack_cnt - CNT_W'(1));
    assign stack_top   = stack_empty ? '0 : stack_mem[top_idx];

    // One action per cycle, highest-priority strobe wins.
    always_comb begin
        pc_nxt  = pc_out;
        cnt_nxt = stack_cnt;
        err_nxt = stack_err;
        push    = 1'b0;
        if (reset) begin
            pc_nxt  = RESET_VEC;
            cnt_nxt = '0;
            err_nxt = 1'b0;
        end else if (pc_call) begin
            if (stack_full) begin
                err_nxt = 1'b1;
            end else begin
                push    = 1'b1;
                cnt_nxt = stack_cnt + CNT_W'(1);
                pc_nxt  = jmp_add;
            end
        end else if (pc_ret) begin
            if (stack_empty) begin
                err_nxt = 1'b1;
            end else begin
                pc_nxt  = stack_top;
                cnt_nxt = stack_cnt - CNT_W'(1);
            end
        end else if (pc_load) begin
            pc_nxt = jmp_add;
`ifdef PC_REL_BRANCH_EN
        end else if (pc_rel) begin
            pc_nxt = rel_target(pc_out, rel_off);
`endif
        end else if (pc_inc) begin
            pc_nxt = pc_out + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_out    <= RESET_VEC;
            stack_cnt <= '0;
            stack_err <= 1'b0;
        end else begin
            pc_out    <= pc_nxt;
            stack_cnt <= cnt_nxt;
            stack_err <= err_nxt;
        end
    end

    // Stack storage carries no reset; an empty count masks stale entries.
    always_ff @(posedge clk) begin
        if (push) begin
            stack_mem[wr_idx] <= pc_out + ADDR_W'(1);
        end
    end

endmodule

// File: tb/tb_pc_stack_unit.sv
// Table-driven bench for pc_stack_unit plus directed overflow/reset/relative sequences.
// Relative-branch checks are built only when PC_REL_BRANCH_EN is defined.
module tb_pc_stack_unit;

    logic        clk = 1'b0;
    logic        reset, pc_inc, pc_load, pc_call, pc_ret;
`ifdef PC_REL_BRANCH_EN
    logic        pc_rel;
    logic signed [7:0] rel_off;
`endif
    logic [15:0] jmp_add;
    logic [15:0] pc_out, stack_top;
    logic [3:0]  stack_cnt;
    logic        stack_full, stack_empty, stack_err;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    pc_stack_unit #(.ADDR_W(16), .STACK_DEPTH(8), .RESET_VEC(16'h0000)) dut (
        .clk        (clk),
        .reset      (reset),
        .pc_inc     (pc_inc),
        .pc_load    (pc_load),
        .pc_call    (pc_call),
        .pc_ret     (pc_ret),
`ifdef PC_REL_BRANCH_EN
        .pc_rel     (pc_rel),
        .rel_off    (rel_off),
`endif
        .jmp_add    (jmp_add),
        .pc_out     (pc_out),
        .stack_top  (stack_top),
        .stack_cnt  (stack_cnt),
        .stack_full (stack_full),
        .stack_empty(stack_empty),
        .stack_err  (stack_err)
    );

    typedef struct {
        string       name;
        logic        rst, inc, load, call, ret;
        logic [15:0] jmp;
        logic [15:0] e_pc;
        logic [3:0]  e_cnt;
        logic [15:0] e_top;
        logic        e_err;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(string n, logic r, logic i, logic l, logic c, logic t,
                                logic [15:0] j, logic [15:0] p, logic [3:0] cn,
                                logic [15:0] tp, logic e);
        vec_t v;
        v.name = n; v.rst = r; v.inc = i; v.load = l; v.call = c; v.ret = t;
        v.jmp = j; v.e_pc = p; v.e_cnt = cn; v.e_top = tp; v.e_err = e;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Drive strobes between edges, then let one rising edge consume them.
    task automatic drive(logic r, logic i, logic l, logic c, logic t, logic [15:0] j);
        @(negedge clk);
        reset = r; pc_inc = i; pc_load = l; pc_call = c; pc_ret = t; jmp_add = j;
`ifdef PC_REL_BRANCH_EN
        pc_rel = 1'b0; rel_off = '0;
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(string nm, logic [15:0] p, logic [3:0] cn,
                               logic [15:0] tp, logic e);
        chk({nm, ".pc"},    32'(pc_out),    32'(p));
        chk({nm, ".cnt"},   32'(stack_cnt), 32'(cn));
        chk({nm, ".top"},   32'(stack_top), 32'(tp));
        chk({nm, ".err"},   32'(stack_err), 32'(e));
        chk({nm, ".full"},  32'(stack_full),  32'(cn == 4'd8));
        chk({nm, ".empty"}, 32'(stack_empty), 32'(cn == 4'd0));
    endtask

`ifdef PC_REL_BRANCH_EN
    task automatic drive_rel(logic r, logic i, logic l, logic [7:0] off, logic [15:0] j);
        @(negedge clk);
        reset = r; pc_inc = i; pc_load = l; pc_call = 1'b0; pc_ret = 1'b0; jmp_add = j;
        pc_rel = 1'b1; rel_off = off;
        @(posedge clk);
        #1;
    endtask
`endif

    initial begin
        logic [15:0] exp_push [8];
        logic [15:0] pc_m;

        reset = 1'b1; pc_inc = 1'b0; pc_load = 1'b0; pc_call = 1'b0; pc_ret = 1'b0;
        jmp_add = '0;
`ifdef PC_REL_BRANCH_EN
        pc_rel = 1'b0; rel_off = '0;
`endif

        //               name         rst inc ld call ret jmp       pc       cnt top      err
        vecs[0]  = mk("reset",        1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0);
        vecs[1]  = mk("inc1",         0, 1, 0, 0, 0, 16'h0000, 16'h0001, 0, 16'h0000, 0);
        vecs[2]  = mk("inc2",         0, 1, 0, 0, 0, 16'h0000, 16'h0002, 0, 16'h0000, 0);
        vecs[3]  = mk("inc3",         0, 1, 0, 0, 0, 16'h0000, 16'h0003, 0, 16'h0000, 0);
        vecs[4]  = mk("load5",        0, 0, 1, 0, 0, 16'h0005, 16'h0005, 0, 16'h0000, 0);
        vecs[5]  = mk("call1000",     0, 0, 0, 1, 0, 16'h1000, 16'h1000, 1, 16'h0006, 0);
        vecs[6]  = mk("ret_b2b",      0, 0, 0, 0, 1, 16'h0000, 16'h0006, 0, 16'h0000, 0);
        vecs[7]  = mk("call_and_ret", 0, 0, 0, 1, 1, 16'h0200, 16'h0200, 1, 16'h0007, 0);
        vecs[8]  = mk("load_and_inc", 0, 1, 1, 0, 0, 16'h0400, 16'h0400, 1, 16'h0007, 0);
        vecs[9]  = mk("loadFFFF",     0, 0, 1, 0, 0, 16'hFFFF, 16'hFFFF, 1, 16'h0007, 0);
        vecs[10] = mk("inc_wrap",     0, 1, 0, 0, 0, 16'h0000, 16'h0000, 1, 16'h0007, 0);
        vecs[11] = mk("ret_pop",      0, 0, 0, 0, 1, 16'h0000, 16'h0007, 0, 16'h0000, 0);
        vecs[12] = mk("ret_under",    0, 0, 0, 0, 1, 16'h0000, 16'h0007, 0, 16'h0000, 1);
        vecs[13] = mk("inc_sticky",   0, 1, 0, 0, 0, 16'h0000, 16'h0008, 0, 16'h0000, 1);
        vecs[14] = mk("call_sticky",  0, 0, 0, 1, 0, 16'h0300, 16'h0300, 1, 16'h0009, 1);
        vecs[15] = mk("reset_call",   1, 0, 0, 1, 0, 16'h0700, 16'h0000, 0, 16'h0000, 0);
        vecs[16] = mk("under_rst",    0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 16'h0000, 1);
        vecs[17] = mk("reset_clr",    1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0);

        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].rst, vecs[i].inc, vecs[i].load, vecs[i].call, vecs[i].ret, vecs[i].jmp);
            check_state(vecs[i].name, vecs[i].e_pc, vecs[i].e_cnt, vecs[i].e_top, vecs[i].e_err);
        end

        // Overflow: eight nested calls fill the stack, a ninth is rejected.
        drive(1, 0, 0, 0, 0, 16'h0000);
        drive(0, 0, 1, 0, 0, 16'h0100);
        pc_m = 16'h0100;
        for (int i = 0; i < 8; i++) begin
            exp_push[i] = pc_m + 16'd1;
            pc_m = 16'h1000 + 16'(i * 16);
            drive(0, 0, 0, 1, 0, pc_m);
            check_state($sformatf("nest%0d", i), pc_m, 4'(i + 1), exp_push[i], 1'b0);
        end
        drive(0, 0, 0, 1, 0, 16'h2000);
        check_state("overflow", pc_m, 4'd8, exp_push[7], 1'b1);
        for (int i = 7; i >= 0; i--) begin
            drive(0, 0, 0, 0, 1, 16'h0000);
            check_state($sformatf("unwind%0d", i), exp_push[i], 4'(i),
                        (i > 0) ? exp_push[(i > 0) ? i - 1 : 0] : 16'h0000, 1'b1);
        end

        // Reset between CALL and RET discards the pushed entry.
        drive(1, 0, 0, 0, 0, 16'h0000);
        drive(0, 0, 1, 0, 0, 16'h0040);
        drive(0, 0, 0, 1, 0, 16'h0500);
        check_state("mid_call", 16'h0500, 4'd1, 16'h0041, 1'b0);
        drive(1, 0, 0, 0, 0, 16'h0000);
        check_state("mid_reset", 16'h0000, 4'd0, 16'h0000, 1'b0);
        drive(0, 0, 0, 0, 1, 16'h0000);
        check_state("mid_ret", 16'h0000, 4'd0, 16'h0000, 1'b1);

`ifdef PC_REL_BRANCH_EN
        drive(1, 0, 0, 0, 0, 16'h0000);
        drive(0, 0, 1, 0, 0, 16'h0010);
        drive_rel(0, 0, 0, 8'hFE, 16'h0000);
        chk("rel_back", 32'(pc_out), 32'h000E);
        drive(0, 0, 1, 0, 0, 16'hFFF0);
        drive_rel(0, 0, 0, 8'h20, 16'h0000);
        chk("rel_wrap", 32'(pc_out), 32'h0010);
        drive_rel(0, 1, 0, 8'h05, 16'h0000);
        chk("rel_over_inc", 32'(pc_out), 32'h0015);
        drive_rel(0, 0, 1, 8'h05, 16'h0ABC);
        chk("load_over_rel", 32'(pc_out), 32'h0ABC);
        drive_rel(1, 0, 0, 8'h05, 16'h0000);
        chk("reset_over_rel", 32'(pc_out), 32'h0000);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pc_stack_unit.md
# pc_stack_unit

Parametrised program-counter unit with a hardware return-address stack, for the instruction-fetch path of the Dyna-85 core. Supports reset to a vector, increment, absolute jump, CALL and RET through an internal LIFO, and an optional PC-relative branch. The control unit drives one-cycle strobes. `pc_out` addresses program memory directly.

## Interface
Parameters:
- `ADDR_W`, 16, width of the PC and of stack entries.
- `STACK_DEPTH`, 8, number of return-address entries. Legal range 2..64.
- `RESET_VEC`, 0, value loaded into `pc_out` on reset.

Ports:
- `clk`  in  1  single clock. All state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `pc_inc`  in  1  advance PC by 1.
- `pc_load`  in  1  absolute jump to `jmp_add`.
- `pc_call`  in  1  push return address, then jump to `jmp_add`.
- `pc_ret`  in  1  pop top of stack into PC.
- `pc_rel`  in  1  relative branch by `rel_off`. Present only when `PC_REL_BRANCH_EN` is defined.
- `rel_off`  in  8  signed two's-complement offset. Present only when `PC_REL_BRANCH_EN` is defined.
- `jmp_add`  in  ADDR_W  jump/call target.
- `pc_out`  out  ADDR_W  current PC (registered).
- `stack_top`  out  ADDR_W  current top-of-stack entry. Reads 0 when the stack is empty.
- `stack_cnt`  out  $clog2(STACK_DEPTH+1)  number of valid entries.
- `stack_full`  out  1  `stack_cnt == STACK_DEPTH`.
- `stack_empty`  out  1  `stack_cnt == 0`.
- `stack_err`  out  1  sticky flag for overflow or underflow.

## Operation
- One action is executed per cycle, chosen by priority: `reset` > `pc_call` > `pc_ret` > `pc_load` > `pc_rel` > `pc_inc` > hold. Lower-priority strobes in the same cycle are ignored with no side effects.
- reset:
  - `pc_out` = `RESET_VEC`.
  - `stack_cnt` = 0.
  - `stack_err` = 0.
  - Stack RAM contents are don't-care; `stack_top` reads 0 while the stack is empty.
  - Reset asserted mid-sequence (e.g. between CALL and RET) discards all stack state.
- CALL when not full:
  - Writes `pc_out + 1` (mod 2^ADDR_W) at index `stack_cnt`.
  - Increments `stack_cnt` and sets `pc_out` = `jmp_add`.
- CALL when full: no push, `pc_out` unchanged, `stack_err` set to 1.
- RET when not empty: `pc_out` = entry[`stack_cnt`-1] and `stack_cnt` decrements.
- RET when empty: `pc_out` unchanged, `stack_err` set to 1.
- LOAD: `pc_out` = `jmp_add`. The stack is untouched.
- REL: `pc_out` = `pc_out` + sign-extend(`rel_off`), mod 2^ADDR_W.
- INC: `pc_out` = `pc_out` + 1, wrapping from all-ones to 0.
- `stack_err` is cleared only by reset.

## Timing
- Every action takes effect at the rising edge where its strobe is sampled high, so `pc_out` shows the new value in the following cycle.
- `stack_top`, `stack_full`, `stack_empty` and `stack_cnt` are derived from registered state only. They update in the same cycle as `pc_out`.
- There is no combinational path from any input to any output.
- Back-to-back CALL/RET on consecutive cycles must work without bubbles: CALL in cycle n and RET in cycle n+1 returns the address pushed in cycle n.

## Configuration
- `PC_REL_BRANCH_EN` defined:
  - `pc_rel` and `rel_off` ports exist.
  - REL sits in the priority slot defined above.
- `PC_REL_BRANCH_EN` undefined:
  - `pc_rel` and `rel_off` ports are removed.
  - The priority chain skips REL. All other behaviour is identical.

## Test plan
- Reset and increment: `RESET_VEC`=0, reset then 3 cycles of `pc_inc` -> `pc_out`=0x0003, `stack_empty`=1, `stack_err`=0.
- CALL then RET:
  - `pc_out`=0x0005, `pc_call` with `jmp_add`=0x1000 -> `pc_out`=0x1000, `stack_top`=0x0006, `stack_cnt`=1.
  - Next cycle `pc_ret` -> `pc_out`=0x0006, `stack_empty`=1.
- Overflow with `STACK_DEPTH`=8: 8 nested calls -> `stack_full`=1. A 9th call to 0x2000 -> `pc_out` unchanged, `stack_cnt`=8, `stack_err`=1. Then 8 RETs return the pushed addresses in LIFO order.
- Underflow: after reset, `pc_ret` -> `pc_out`=`RESET_VEC`, `stack_err`=1. Error stays 1 through later valid ops until reset.
- Wrap and priority:
  - `pc_out`=0xFFFF with `pc_inc` -> 0x0000.
  - `pc_load` (0x0400) with `pc_inc` in the same cycle -> 0x0400.
  - `pc_call` with `pc_ret` in the same cycle -> call only, `stack_cnt`+1.
- Relative (`PC_REL_BRANCH_EN` defined):
  - `pc_out`=0x0010 with `rel_off`=0xFE -> 0x000E.
  - `pc_out`=0xFFF0 with `rel_off`=0x20 -> 0x0010.
  - Reset asserted in the same cycle as `pc_rel` -> `RESET_VEC`.
